// File: rtl/dram_pkg.sv
// Shared DRAM controller definitions: command codes, address-map field
// positions, the queued request record and the scheduler state type.
package dram_pkg;

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_PRE = 3'd1;
    localparam logic [2:0] CMD_ACT = 3'd2;
    localparam logic [2:0] CMD_RD  = 3'd3;
    localparam logic [2:0] CMD_WR  = 3'd4;

    // Address map: {2'b0, row[29:16], bg[15:14], bank[13:12], col[11:4], 4'b0}
    localparam int ROW_MSB  = 29;
    localparam int ROW_LSB  = 16;
    localparam int BG_MSB   = 15;
    localparam int BG_LSB   = 14;
    localparam int BANK_MSB = 13;
    localparam int BANK_LSB = 12;
    localparam int COL_MSB  = 11;
    localparam int COL_LSB  = 4;
    localparam int ROW_W    = ROW_MSB - ROW_LSB + 1;

    typedef struct packed {
        logic [31:0] addr;
        logic        rw;
        logic [31:0] wdata;
    } req_t;

    typedef enum logic {
        SEL  = 1'b0,
        BUSY = 1'b1
    } sched_state_t;

    // {bg,bank} flattened into the shadow-row table index
    function automatic logic [3:0] bank_of(input logic [31:0] addr);
        return addr[BG_MSB:BANK_LSB];
    endfunction

endpackage

// File: rtl/frfcfs_pick.sv
// Combinational priority picker: lowest-index valid, eligible row hit, else
// the oldest slot. A forced pick always returns the oldest slot.
module frfcfs_pick #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [N-1:0]  hit,
    input  logic [N-1:0]  eligible,
    input  logic          force_oldest,
    output logic [IW-1:0] idx,
    output logic          found
);

    // Scan downward so the lowest matching index wins; the queue is collapsed,
    // so slot 0 being valid means something is pending.
    always_comb begin
        idx   = '0;
        found = valid[0];
        if (!force_oldest) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (valid[i] && hit[i] && eligible[i]) begin
                    idx = IW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/frfcfs_scheduler.sv
// FR-FCFS request buffer in front of generate_instruction. Collapsing queue
// (slot 0 oldest), row-hit preference with a bypass cap on the oldest entry,
// and same-address ordering through the eligibility mask.
module frfcfs_scheduler
    import dram_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int MAX_BYPASS = 4,
    parameter int NUM_BANKS  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_rw,
    input  logic [31:0] req_wdata,
    output logic [31:0] address,
    output logic        r_w,
    output logic [31:0] write_data,
    output logic        fifo_empty,
    input  logic        pop,
    input  logic [2:0]  command,
    output logic [15:0] hit_sel_cnt
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = $clog2(MAX_BYPASS + 1);

    req_t               slot_q [DEPTH];
    req_t               slot_d [DEPTH];
    logic [CW-1:0]      count_q;
    logic [CW-1:0]      count_d;
    logic [CW-1:0]      wr_idx;
    sched_state_t       state_q;
    sched_state_t       state_d;
    logic [IW-1:0]      sel_idx_q;
    logic [IW-1:0]      pick_idx;
    logic               pick_found;
    logic [BW-1:0]      bypass_cnt;
    logic [NUM_BANKS-1:0] shadow_valid;
    logic [ROW_W-1:0]   shadow_row [NUM_BANKS];
    logic [DEPTH-1:0]   valid_vec;
    logic [DEPTH-1:0]   hit_vec;
    logic [DEPTH-1:0]   elig;
    logic               enq;
    logic               pop_ok;
    logic               do_sel;
    logic               force_oldest;

    // Ready is based on the pre-pop count, so a full queue never passes a
    // request through in the same cycle it pops.
    assign req_ready    = (count_q < CW'(DEPTH));
    assign enq          = req_valid && req_ready;
    assign pop_ok       = pop && (state_q == BUSY);
    assign do_sel       = (state_q == SEL) && pick_found;
    assign force_oldest = (bypass_cnt == BW'(MAX_BYPASS));

    // Per-slot valid, open-row hit and same-address ordering mask
    always_comb begin
        valid_vec = '0;
        hit_vec   = '0;
        elig      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_vec[i] = (CW'(i) < count_q);
            hit_vec[i]   = shadow_valid[bank_of(slot_q[i].addr)] &&
                           (shadow_row[bank_of(slot_q[i].addr)] == slot_q[i].addr[ROW_MSB:ROW_LSB]);
            elig[i]      = 1'b1;
            for (int j = 0; j < i; j++) begin
                if ((slot_q[j].addr[ROW_MSB:COL_LSB] == slot_q[i].addr[ROW_MSB:COL_LSB]) &&
                    (slot_q[i].rw || slot_q[j].rw)) begin
                    elig[i] = 1'b0;
                end
            end
        end
    end

    frfcfs_pick #(.N(DEPTH), .IW(IW)) u_pick (
        .valid        (valid_vec),
        .hit          (hit_vec),
        .eligible     (elig),
        .force_oldest (force_oldest),
        .idx          (pick_idx),
        .found        (pick_found)
    );

    // Next state: a selection locks until the controller pops it
    always_comb begin
        state_d = state_q;
        case (state_q)
            SEL:     if (pick_found) state_d = BUSY;
            BUSY:    if (pop)        state_d = SEL;
            default: state_d = SEL;
        endcase
    end

    // Queue update: collapse the popped slot first, then append the new entry
    always_comb begin
        slot_d  = slot_q;
        count_d = count_q;
        wr_idx  = count_q;
        if (pop_ok) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (IW'(i) >= sel_idx_q) begin
                    slot_d[i] = slot_q[i + 1];
                end
            end
            count_d = count_q - CW'(1);
            wr_idx  = count_q - CW'(1);
        end
        if (enq) begin
            slot_d[wr_idx[IW-1:0]].addr  = req_addr;
            slot_d[wr_idx[IW-1:0]].rw    = req_rw;
            slot_d[wr_idx[IW-1:0]].wdata = req_wdata;
            count_d = count_d + CW'(1);
        end
    end

    // State and occupancy registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SEL;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Slot payload storage; occupancy alone says what is live
    always_ff @(posedge clk) begin
        slot_q <= slot_d;
    end

    // Presented request, bypass bookkeeping and hit statistics
    always_ff @(posedge clk) begin
        if (reset) begin
            address     <= '0;
            r_w         <= 1'b0;
            write_data  <= '0;
            fifo_empty  <= 1'b1;
            sel_idx_q   <= '0;
            bypass_cnt  <= '0;
            hit_sel_cnt <= '0;
        end else if (do_sel) begin
            address    <= slot_q[pick_idx].addr;
            r_w        <= slot_q[pick_idx].rw;
            write_data <= slot_q[pick_idx].wdata;
            fifo_empty <= 1'b0;
            sel_idx_q  <= pick_idx;
            if (pick_idx == '0) begin
                bypass_cnt <= '0;
            end else if (bypass_cnt != BW'(MAX_BYPASS)) begin
                bypass_cnt <= bypass_cnt + BW'(1);
            end
            // Only a hit can pick a non-zero slot, so this counts bypassing hits
            if ((pick_idx != '0) && (hit_sel_cnt != 16'hFFFF)) begin
                hit_sel_cnt <= hit_sel_cnt + 16'd1;
            end
        end else if (pop_ok) begin
            fifo_empty <= 1'b1;
        end
    end

    // Shadow open-row validity follows ACT/PRE on the presented bank
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_valid <= '0;
        end else if (command == CMD_ACT) begin
            shadow_valid[bank_of(address)] <= 1'b1;
        end else if (command == CMD_PRE) begin
            shadow_valid[bank_of(address)] <= 1'b0;
        end
    end

    // Shadow row value; meaningless while its valid bit is clear
    always_ff @(posedge clk) begin
        if (!reset && (command == CMD_ACT)) begin
            shadow_row[bank_of(address)] <= address[ROW_MSB:ROW_LSB];
        end
    end

    // A pop with nothing presented is a controller bug
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(pop && (state_q == SEL)));
        end
    end

endmodule

// File: tb/tb_frfcfs_scheduler.sv
// Directed bench for frfcfs_scheduler. The bench plays generate_instruction:
// it keeps its own open-row table and issues PRE/ACT/RD/WR as needed.
module tb_frfcfs_scheduler;
    import dram_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_rw;
    logic [31:0] req_wdata;
    logic [31:0] address;
    logic        r_w;
    logic [31:0] write_data;
    logic        fifo_empty;
    logic        pop;
    logic [2:0]  command;
    logic [15:0] hit_sel_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic        m_valid [16];
    logic [13:0] m_row   [16];

    logic [31:0] a1, mreq, hreq, p, u, w, rd, x, m2, h2;
    logic [31:0] e [11];
    logic [31:0] hh [6];

    frfcfs_scheduler #(.DEPTH(8), .MAX_BYPASS(4), .NUM_BANKS(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_rw      (req_rw),
        .req_wdata   (req_wdata),
        .address     (address),
        .r_w         (r_w),
        .write_data  (write_data),
        .fifo_empty  (fifo_empty),
        .pop         (pop),
        .command     (command),
        .hit_sel_cnt (hit_sel_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [13:0] row, input logic [1:0] bg,
                                       input logic [1:0] bank, input logic [7:0] col);
        return {2'b00, row, bg, bank, col, 4'b0000};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_row[i]   = '0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_rw = 1'b0; req_wdata = '0;
        pop = 1'b0; command = CMD_NOP;
        tick();
        tick();
        reset = 1'b0;
        clear_model();
    endtask

    task automatic enq(input logic [31:0] a, input logic rw, input logic [31:0] wd);
        req_valid = 1'b1; req_addr = a; req_rw = rw; req_wdata = wd;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_present(input string tag);
        int n;
        n = 0;
        while (fifo_empty && n < 20) begin
            tick();
            n++;
        end
        check_eq({tag, "_present"}, fifo_empty, 1'b0);
    endtask

    task automatic serve(input logic [31:0] exp_addr, input logic exp_rw, input logic [31:0] exp_wd,
                         input string tag, input logic enq_on_pop, input logic [31:0] enq_addr);
        logic [3:0]  b;
        logic [13:0] row;
        wait_present(tag);
        check_eq({tag, "_addr"}, address, exp_addr);
        check_eq({tag, "_rw"}, r_w, exp_rw);
        check_eq({tag, "_wdata"}, write_data, exp_wd);
        b   = exp_addr[15:12];
        row = exp_addr[29:16];
        if (m_valid[b] && m_row[b] != row) begin
            command = CMD_PRE;
            tick();
            m_valid[b] = 1'b0;
        end
        if (!m_valid[b]) begin
            command = CMD_ACT;
            tick();
            m_valid[b] = 1'b1;
            m_row[b]   = row;
        end
        check_eq({tag, "_hold"}, address, exp_addr);
        command = exp_rw ? CMD_WR : CMD_RD;
        pop     = 1'b1;
        if (enq_on_pop) begin
            req_valid = 1'b1; req_addr = enq_addr; req_rw = 1'b0; req_wdata = '0;
        end
        tick();
        pop     = 1'b0;
        command = CMD_NOP;
        if (enq_on_pop) req_valid = 1'b0;
        check_eq({tag, "_done"}, fifo_empty, 1'b1);
    endtask

    initial begin
        reset = 1'b1;
        a1   = mk(14'h1234, 2'd0, 2'd0, 8'h10);
        mreq = mk(14'h1678, 2'd0, 2'd0, 8'h20);
        hreq = mk(14'h1234, 2'd0, 2'd0, 8'h30);

        // T1: single read, latency and reset values
        do_reset();
        check_eq("rst_address", address, 32'h0);
        check_eq("rst_rw", r_w, 1'b0);
        check_eq("rst_wdata", write_data, 32'h0);
        check_eq("rst_empty", fifo_empty, 1'b1);
        check_eq("rst_hitcnt", hit_sel_cnt, 16'h0);
        check_eq("rst_ready", req_ready, 1'b1);
        req_valid = 1'b1; req_addr = a1; req_rw = 1'b0; req_wdata = '0;
        tick();
        req_valid = 1'b0;
        check_eq("t1_lat1", fifo_empty, 1'b1);
        tick();
        check_eq("t1_lat2", fifo_empty, 1'b0);
        serve(a1, 1'b0, 32'h0, "t1", 1'b0, 32'h0);

        // T2: younger hit overtakes an older miss
        do_reset();
        enq(a1, 1'b0, 32'h0);
        wait_present("t2_a1w");
        enq(mreq, 1'b0, 32'h0);
        enq(hreq, 1'b0, 32'h0);
        serve(a1, 1'b0, 32'h0, "t2_a1", 1'b0, 32'h0);
        serve(hreq, 1'b0, 32'h0, "t2_hit", 1'b0, 32'h0);
        check_eq("t2_hitcnt", hit_sel_cnt, 16'd1);
        check_eq("t2_bypass", dut.bypass_cnt, 32'd1);
        serve(mreq, 1'b0, 32'h0, "t2_miss", 1'b0, 32'h0);
        check_eq("t2_bypass_clr", dut.bypass_cnt, 32'd0);
        check_eq("t2_hitcnt2", hit_sel_cnt, 16'd1);

        // T3: bypass cap forces the oldest miss out after four hits
        do_reset();
        for (int k = 0; k < 6; k++) hh[k] = mk(14'h1234, 2'd0, 2'd0, 8'(8'h21 + k));
        enq(a1, 1'b0, 32'h0);
        wait_present("t3_a1w");
        enq(mreq, 1'b0, 32'h0);
        for (int k = 0; k < 6; k++) enq(hh[k], 1'b0, 32'h0);
        check_eq("t3_full", req_ready, 1'b0);
        serve(a1, 1'b0, 32'h0, "t3_a1", 1'b0, 32'h0);
        serve(hh[0], 1'b0, 32'h0, "t3_h1", 1'b0, 32'h0);
        serve(hh[1], 1'b0, 32'h0, "t3_h2", 1'b0, 32'h0);
        serve(hh[2], 1'b0, 32'h0, "t3_h3", 1'b0, 32'h0);
        serve(hh[3], 1'b0, 32'h0, "t3_h4", 1'b0, 32'h0);
        check_eq("t3_bypass_sat", dut.bypass_cnt, 32'd4);
        serve(mreq, 1'b0, 32'h0, "t3_miss", 1'b0, 32'h0);
        serve(hh[4], 1'b0, 32'h0, "t3_h5", 1'b0, 32'h0);
        serve(hh[5], 1'b0, 32'h0, "t3_h6", 1'b0, 32'h0);
        check_eq("t3_hitcnt", hit_sel_cnt, 16'd4);

        // T4: read never overtakes an older write to the same address
        do_reset();
        p  = 32'h0001_2100;
        u  = mk(14'h0055, 2'd0, 2'd0, 8'h01);
        w  = 32'h0001_2340;
        rd = 32'h0001_2340;
        enq(p, 1'b0, 32'h0);
        wait_present("t4_pw");
        enq(u, 1'b0, 32'h0);
        enq(w, 1'b1, 32'hDEAD_BEEF);
        enq(rd, 1'b0, 32'h0);
        check_eq("t4_elig", {28'h0, dut.elig[3:0]}, 32'h7);
        serve(p, 1'b0, 32'h0, "t4_p", 1'b0, 32'h0);
        serve(w, 1'b1, 32'hDEAD_BEEF, "t4_w", 1'b0, 32'h0);
        serve(rd, 1'b0, 32'h0, "t4_r", 1'b0, 32'h0);
        serve(u, 1'b0, 32'h0, "t4_u", 1'b0, 32'h0);

        // T5: full backpressure, held request, simultaneous enqueue and pop
        do_reset();
        for (int k = 0; k < 11; k++) e[k] = mk(14'(14'h100 + k), 2'd0, 2'd0, 8'(k));
        for (int k = 0; k < 8; k++) enq(e[k], 1'b0, 32'h0);
        check_eq("t5_full", req_ready, 1'b0);
        req_valid = 1'b1; req_addr = e[8]; req_rw = 1'b0; req_wdata = '0;
        tick();
        tick();
        check_eq("t5_held", req_ready, 1'b0);
        serve(e[0], 1'b0, 32'h0, "t5_e0", 1'b0, 32'h0);
        check_eq("t5_ready_after_pop", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
        check_eq("t5_refull", req_ready, 1'b0);
        serve(e[1], 1'b0, 32'h0, "t5_e1", 1'b0, 32'h0);
        serve(e[2], 1'b0, 32'h0, "t5_e2", 1'b1, e[9]);
        check_eq("t5_swap_ready", req_ready, 1'b1);
        enq(e[10], 1'b0, 32'h0);
        check_eq("t5_full_again", req_ready, 1'b0);
        for (int k = 3; k < 11; k++) serve(e[k], 1'b0, 32'h0, $sformatf("t5_e%0d", k), 1'b0, 32'h0);

        // T6: reset while busy drops everything, including open rows
        do_reset();
        enq(a1, 1'b0, 32'h0);
        serve(a1, 1'b0, 32'h0, "t6_a1", 1'b0, 32'h0);
        for (int k = 0; k < 5; k++) enq(mk(14'(14'h200 + k), 2'd0, 2'd0, 8'h00), 1'b0, 32'h0);
        check_eq("t6_busy", fifo_empty, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_model();
        check_eq("t6_empty", fifo_empty, 1'b1);
        check_eq("t6_ready", req_ready, 1'b1);
        check_eq("t6_address", address, 32'h0);
        check_eq("t6_hitcnt", hit_sel_cnt, 16'h0);
        check_eq("t6_shadow", {16'h0, dut.shadow_valid}, 32'h0);
        x  = mk(14'h0400, 2'd0, 2'd1, 8'h00);
        m2 = mk(14'h0300, 2'd0, 2'd0, 8'h05);
        h2 = mk(14'h1234, 2'd0, 2'd0, 8'h07);
        enq(x, 1'b0, 32'h0);
        wait_present("t6_xw");
        enq(m2, 1'b0, 32'h0);
        enq(h2, 1'b0, 32'h0);
        serve(x, 1'b0, 32'h0, "t6_x", 1'b0, 32'h0);
        serve(m2, 1'b0, 32'h0, "t6_m2", 1'b0, 32'h0);
        serve(h2, 1'b0, 32'h0, "t6_h2", 1'b0, 32'h0);
        check_eq("t6_hitcnt_end", hit_sel_cnt, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
